// File: rtl/m68k_bus_initiator.sv
// 68000-style asynchronous bus master: single byte read/write cycles driven from a
// command/response port, completed on a synchronized _dtack with bounded waits.
module m68k_bus_initiator #(
    parameter int         ADDR_W  = 20,
    parameter int         DATA_W  = 8,
    parameter int         TIMEOUT = 255,
    parameter logic [1:0] FC_CODE = 2'b01
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rw,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] d_out,
    output logic              d_oe,
    input  logic [DATA_W-1:0] d_in,
    output logic              _as,
    output logic              _ds,
    output logic              rw,
    output logic              fc0,
    output logic              fc1,
    input  logic              _dtack
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W:0] TMO_EXT = (CNT_W + 1)'(TIMEOUT);
    localparam logic [CNT_W:0] CNT_ONE = {{CNT_W{1'b0}}, 1'b1};

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_STROBE  = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rw_q, rw_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              doe_q, doe_d;
    logic              as_q, as_d;
    logic              ds_q, ds_d;
    logic              rvalid_q, rvalid_d;
    logic              rerr_q, rerr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              dtk_meta_q, dtk_s_q;

    logic [CNT_W:0]    cnt_inc;
    logic              tmo_hit;

    // Counter stops at TIMEOUT, so the extra bit only guards the compare.
    assign cnt_inc = {1'b0, cnt_q} + CNT_ONE;
    assign tmo_hit = (cnt_inc >= TMO_EXT);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        addr_d   = addr_q;
        rw_d     = rw_q;
        dout_d   = dout_q;
        doe_d    = doe_q;
        as_d     = as_q;
        ds_d     = ds_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        rerr_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && ready_q) begin
                    addr_d  = cmd_addr;
                    rw_d    = cmd_rw;
                    doe_d   = ~cmd_rw;
                    if (!cmd_rw) dout_d = cmd_wdata;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                as_d    = 1'b0;
                ds_d    = 1'b0;
                cnt_d   = '0;
                state_d = S_STROBE;
            end
            S_STROBE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!dtk_s_q || tmo_hit) begin
                    if (!dtk_s_q) begin
                        if (rw_q) rdata_d = d_in;
                    end else begin
                        err_d = 1'b1;
                    end
                    as_d    = 1'b1;
                    ds_d    = 1'b1;
                    doe_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RELEASE;
                end else begin
                    cnt_d = cnt_inc[CNT_W-1:0];
                end
            end
            S_RELEASE: begin
                if (dtk_s_q) begin
                    rvalid_d = 1'b1;
                    rerr_d   = err_q;
                    state_d  = S_DONE;
                end else if (tmo_hit) begin
                    err_d    = 1'b1;
                    rvalid_d = 1'b1;
                    rerr_d   = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_inc[CNT_W-1:0];
                end
            end
            S_DONE: begin
                err_d   = 1'b0;
                rw_d    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            rw_q       <= 1'b1;
            dout_q     <= '0;
            doe_q      <= 1'b0;
            as_q       <= 1'b1;
            ds_q       <= 1'b1;
            rvalid_q   <= 1'b0;
            rerr_q     <= 1'b0;
            rdata_q    <= '0;
            ready_q    <= 1'b1;
            dtk_meta_q <= 1'b1;
            dtk_s_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            rw_q       <= rw_d;
            dout_q     <= dout_d;
            doe_q      <= doe_d;
            as_q       <= as_d;
            ds_q       <= ds_d;
            rvalid_q   <= rvalid_d;
            rerr_q     <= rerr_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
            dtk_meta_q <= _dtack;
            dtk_s_q    <= dtk_meta_q;
        end
    end

    assign cmd_ready = ready_q;
    assign rsp_valid = rvalid_q;
    assign rsp_err   = rerr_q;
    assign rsp_rdata = rdata_q;
    assign addr      = addr_q;
    assign d_out     = dout_q;
    assign d_oe      = doe_q;
    assign _as       = as_q;
    assign _ds       = ds_q;
    assign rw        = rw_q;
    assign fc0       = FC_CODE[0];
    assign fc1       = FC_CODE[1];

endmodule

// File: tb/tb_m68k_bus_initiator.sv
// Directed bench for m68k_bus_initiator with a cycle-stepped _dtack responder
// (normal ack, never ack, ack stuck low).
module tb_m68k_bus_initiator;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rw;
    logic [19:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic [19:0] addr;
    logic [7:0]  d_out;
    logic        d_oe;
    logic [7:0]  d_in;
    logic        _as;
    logic        _ds;
    logic        rw;
    logic        fc0;
    logic        fc1;
    logic        _dtack;

    m68k_bus_initiator #(
        .ADDR_W (20),
        .DATA_W (8),
        .TIMEOUT(16),
        .FC_CODE(2'b01)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_rw   (cmd_rw),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .addr     (addr),
        .d_out    (d_out),
        .d_oe     (d_oe),
        .d_in     (d_in),
        ._as      (_as),
        ._ds      (_ds),
        .rw       (rw),
        .fc0      (fc0),
        .fc1      (fc1),
        ._dtack   (_dtack)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // responder: 0 = ack after 4 low samples, 1 = never ack, 2 = ack then stuck low
    int          mode;
    logic [7:0]  drv_data;
    int          as_run;

    int          rv_cnt, as_low_cnt, bad_ready, oe_seen, rw0_seen, ds_bad, wr_bad;
    int          high_run, min_gap;
    logic        had_low, prev_as, got_err, wr_check;
    logic [19:0] exp_addr;
    logic [7:0]  exp_wd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        rv_cnt = 0; as_low_cnt = 0; bad_ready = 0; oe_seen = 0; rw0_seen = 0;
        ds_bad = 0; wr_bad = 0; high_run = 0; min_gap = 1000; had_low = 1'b0;
        prev_as = 1'b1; got_err = 1'b0; wr_check = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rsp_valid === 1'b1) begin
            rv_cnt++;
            got_err = rsp_err;
        end
        if (d_oe === 1'b1) oe_seen++;
        if (rw === 1'b0) rw0_seen++;
        if (_ds !== _as) ds_bad++;
        if (_as === 1'b0) begin
            as_low_cnt++;
            as_run++;
            if (cmd_ready !== 1'b0) bad_ready++;
            if (had_low && prev_as && high_run < min_gap) min_gap = high_run;
            high_run = 0;
            had_low  = 1'b1;
            if (wr_check && !(d_oe === 1'b1 && d_out === exp_wd && rw === 1'b0 && addr === exp_addr))
                wr_bad++;
        end else begin
            as_run = 0;
            high_run++;
        end
        prev_as = _as;
        case (mode)
            0: begin
                if (_as === 1'b0 && as_run >= 4) begin
                    _dtack = 1'b0;
                    d_in   = drv_data;
                end else if (_as !== 1'b0) begin
                    _dtack = 1'b1;
                end
            end
            2: if (_as === 1'b0 && as_run >= 4) _dtack = 1'b0;
            default: _dtack = 1'b1;
        endcase
    endtask

    task automatic issue(input logic r, input logic [19:0] a, input logic [7:0] wd, input logic hold);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        check("ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_rw    = r;
        cmd_addr  = a;
        cmd_wdata = wd;
        step();
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n_rsp, input int budget);
        int n = 0;
        while (rv_cnt < n_rsp && n < budget) begin
            step();
            n++;
        end
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b1; cmd_addr = '0; cmd_wdata = '0;
        d_in = '0; _dtack = 1'b1; mode = 0; drv_data = '0; as_run = 0;
        clear_mon();
        repeat (3) step();
        reset = 1'b0;
        check("rst_as", _as, 1);
        check("rst_ds", _ds, 1);
        check("rst_rw", rw, 1);
        check("rst_doe", d_oe, 0);
        check("rst_addr", addr, 0);
        check("rst_dout", d_out, 0);
        check("rst_rvalid", rsp_valid, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_ready", cmd_ready, 1);
        check("fc_code", {fc1, fc0}, 2'b01);

        // 1: normal read
        clear_mon();
        mode = 0; drv_data = 8'hA5;
        issue(1'b1, 20'h7C000, 8'h00, 1'b0);
        check("t1_addr", addr, 20'h7C000);
        wait_rsp(1, 60);
        check("t1_err", got_err, 0);
        check("t1_rdata", rsp_rdata, 8'hA5);
        repeat (3) step();
        check("t1_rsp_count", rv_cnt, 1);
        check("t1_oe_never", oe_seen, 0);
        check("t1_rw_high", rw0_seen, 0);
        check("t1_as_low_cycles", as_low_cnt, 6);
        check("t1_ds_with_as", ds_bad, 0);

        // 2: write
        clear_mon();
        mode = 0; drv_data = 8'hEE;
        exp_addr = 20'h7A000; exp_wd = 8'h3C; wr_check = 1'b1;
        issue(1'b0, 20'h7A000, 8'h3C, 1'b0);
        check("t2_setup_as", _as, 1);
        check("t2_setup_doe", d_oe, 1);
        check("t2_setup_dout", d_out, 8'h3C);
        check("t2_setup_rw", rw, 0);
        wait_rsp(1, 60);
        check("t2_err", got_err, 0);
        check("t2_doe_off", d_oe, 0);
        repeat (3) step();
        check("t2_rsp_count", rv_cnt, 1);
        check("t2_bus_while_strobe", wr_bad, 0);
        check("t2_ds_with_as", ds_bad, 0);
        check("t2_rw_back", rw, 1);
        check("t2_rdata_kept", rsp_rdata, 8'hA5);

        // 3: _dtack never asserted
        clear_mon();
        mode = 1;
        issue(1'b1, 20'h70000, 8'h00, 1'b0);
        wait_rsp(1, 80);
        check("t3_err", got_err, 1);
        repeat (3) step();
        check("t3_rsp_count", rv_cnt, 1);
        check("t3_as_low_cycles", as_low_cnt, 17);
        check("t3_rdata_kept", rsp_rdata, 8'hA5);

        // 4: _dtack stuck low after ack, then a normal read
        clear_mon();
        mode = 2;
        issue(1'b0, 20'h74000, 8'h81, 1'b0);
        wait_rsp(1, 80);
        check("t4_err", got_err, 1);
        check("t4_rsp_count", rv_cnt, 1);
        mode = 0; drv_data = 8'h5A;
        clear_mon();
        issue(1'b1, 20'h7C001, 8'h00, 1'b0);
        wait_rsp(1, 60);
        check("t4_next_rsp", rv_cnt, 1);
        check("t4_next_err", got_err, 0);
        check("t4_next_rdata", rsp_rdata, 8'h5A);
        repeat (3) step();

        // 5: cmd_valid held across two back-to-back cycles
        clear_mon();
        mode = 0; drv_data = 8'h11;
        issue(1'b1, 20'h78000, 8'h00, 1'b1);
        wait_rsp(2, 120);
        cmd_valid = 1'b0;
        check("t5_rsp_count", rv_cnt, 2);
        check("t5_ready_busy", bad_ready, 0);
        check("t5_gap_ge3", (min_gap >= 3 && min_gap < 1000), 1);
        repeat (4) step();
        check("t5_no_third", rv_cnt, 2);

        // 6: reset during WAIT
        clear_mon();
        mode = 1;
        issue(1'b0, 20'h12345, 8'h77, 1'b0);
        for (int i = 0; i < 20 && as_run < 3; i++) step();
        check("t6_in_wait_as", _as, 0);
        check("t6_in_wait_doe", d_oe, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_as", _as, 1);
        check("t6_ds", _ds, 1);
        check("t6_doe", d_oe, 0);
        check("t6_ready", cmd_ready, 1);
        rv_cnt = 0;
        repeat (25) step();
        check("t6_no_rsp", rv_cnt, 0);
        check("t6_idle_as", _as, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
